// File: rtl/memory_arbiter.sv
// memory_arbiter: round-robin merge of NUM_MASTERS masters onto one slave through a 1-entry request register (1 cycle, no bubble);
// responses routed by smID, combinational unless MEMORY_ARBITER_RESP_REG_EN adds a 1-entry response register; stalls hold all state.
module memory_arbiter #(
  parameter int NUM_MASTERS   = 4,
  parameter int DATA_WIDTH    = 24,
  parameter int ADDRESS_WIDTH = 32,
  parameter int ID_WIDTH      = 4
) (
  input  logic                                        clock,
  input  logic                                        reset,
  input  logic [NUM_MASTERS-1:0]                      in_msValid,
  output logic [NUM_MASTERS-1:0]                      in_msReady,
  input  logic [NUM_MASTERS-1:0]                      in_msWrite,
  input  logic [NUM_MASTERS-1:0][ADDRESS_WIDTH-1:0]   in_msAddress,
  input  logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0]      in_msData,
  input  logic [NUM_MASTERS-1:0][ID_WIDTH-1:0]        in_msID,
  output logic [NUM_MASTERS-1:0]                      in_smValid,
  input  logic [NUM_MASTERS-1:0]                      in_smReady,
  output logic [DATA_WIDTH-1:0]                       in_smData,
  output logic                                        out_msValid,
  output logic                                        out_msWrite,
  output logic [ADDRESS_WIDTH-1:0]                    out_msAddress,
  output logic [DATA_WIDTH-1:0]                       out_msData,
  output logic [ID_WIDTH-1:0]                         out_msID,
  input  logic                                        out_msReady,
  input  logic                                        out_smValid,
  input  logic [DATA_WIDTH-1:0]                       out_smData,
  input  logic [ID_WIDTH-1:0]                         out_smID,
  output logic                                        out_smReady
);

  localparam int PTR_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  typedef struct packed {
    logic                     write;
    logic [ADDRESS_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0]    data;
    logic [ID_WIDTH-1:0]      id;
  } req_t;

  req_t             req_q;
  req_t             req_d;
  logic             full;
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] grant;
  logic [PTR_W-1:0] ptr_next;
  logic             grant_vld;
  logic             load_ok;
  logic             req_load;
  logic             req_drain;

  // First valid master at or above ptr, wrapping past NUM_MASTERS-1.
  always_comb begin
    int idx;
    logic [PTR_W-1:0] cand;
    grant_vld = 1'b0;
    grant     = '0;
    idx       = 0;
    cand      = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      idx  = (int'(ptr) + k) % NUM_MASTERS;
      cand = PTR_W'(idx);
      if (!grant_vld && in_msValid[cand]) begin
        grant_vld = 1'b1;
        grant     = cand;
      end
    end
  end

  assign ptr_next  = PTR_W'((int'(grant) + 1) % NUM_MASTERS);
  assign load_ok   = !full || out_msReady;
  assign req_load  = !reset && load_ok && grant_vld;
  assign req_drain = full && out_msReady;

  always_comb begin
    in_msReady = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      in_msReady[k] = req_load && (grant == PTR_W'(k));
    end
  end

  always_comb begin
    req_d         = '0;
    req_d.write   = in_msWrite[grant];
    req_d.address = in_msAddress[grant];
    req_d.data    = in_msData[grant];
    req_d.id      = in_msID[grant];
  end

  // A drain and a load in the same cycle simply overwrite, keeping full set.
  always_ff @(posedge clock) begin
    if (reset) begin
      full  <= 1'b0;
      ptr   <= '0;
      req_q <= '0;
    end else if (req_load) begin
      full  <= 1'b1;
      ptr   <= ptr_next;
      req_q <= req_d;
    end else if (req_drain) begin
      full  <= 1'b0;
    end
  end

  assign out_msValid   = full;
  assign out_msWrite   = req_q.write;
  assign out_msAddress = req_q.address;
  assign out_msData    = req_q.data;
  assign out_msID      = req_q.id;

  logic sm_mapped;
  assign sm_mapped = int'(out_smID) < NUM_MASTERS;

`ifdef MEMORY_ARBITER_RESP_REG_EN

  logic                  rfull;
  logic [DATA_WIDTH-1:0] rdata;
  logic [ID_WIDTH-1:0]   rid;
  logic                  held_rdy;
  logic                  resp_drain;
  logic                  resp_load;

  always_comb begin
    held_rdy = 1'b0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (rid == ID_WIDTH'(k) && in_smReady[k]) held_rdy = 1'b1;
    end
  end

  assign resp_drain  = rfull && held_rdy;
  assign out_smReady = !rfull || held_rdy;
  // Unmapped IDs are accepted but never occupy the register.
  assign resp_load   = out_smValid && out_smReady && sm_mapped;

  always_ff @(posedge clock) begin
    if (reset) begin
      rfull <= 1'b0;
      rdata <= '0;
      rid   <= '0;
    end else if (resp_load) begin
      rfull <= 1'b1;
      rdata <= out_smData;
      rid   <= out_smID;
    end else if (resp_drain) begin
      rfull <= 1'b0;
    end
  end

  always_comb begin
    in_smValid = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      in_smValid[k] = rfull && (rid == ID_WIDTH'(k));
    end
  end

  assign in_smData = rdata;

`else

  logic routed_rdy;

  always_comb begin
    routed_rdy = 1'b0;
    in_smValid = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      in_smValid[k] = out_smValid && (out_smID == ID_WIDTH'(k));
      if (out_smID == ID_WIDTH'(k) && in_smReady[k]) routed_rdy = 1'b1;
    end
  end

  // Responses for IDs with no master are swallowed.
  assign out_smReady = routed_rdy || !sm_mapped;
  assign in_smData   = out_smData;

`endif

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: grant order, request register, back-pressure, response routing and reset.
module tb_memory_arbiter;

  logic             clock;
  logic             reset;
  logic [3:0]       in_msValid;
  logic [3:0]       in_msReady;
  logic [3:0]       in_msWrite;
  logic [3:0][31:0] in_msAddress;
  logic [3:0][23:0] in_msData;
  logic [3:0][3:0]  in_msID;
  logic [3:0]       in_smValid;
  logic [3:0]       in_smReady;
  logic [23:0]      in_smData;
  logic             out_msValid;
  logic             out_msWrite;
  logic [31:0]      out_msAddress;
  logic [23:0]      out_msData;
  logic [3:0]       out_msID;
  logic             out_msReady;
  logic             out_smValid;
  logic [23:0]      out_smData;
  logic [3:0]       out_smID;
  logic             out_smReady;

  memory_arbiter #(
    .NUM_MASTERS(4), .DATA_WIDTH(24), .ADDRESS_WIDTH(32), .ID_WIDTH(4)
  ) dut (
    .clock(clock), .reset(reset),
    .in_msValid(in_msValid), .in_msReady(in_msReady), .in_msWrite(in_msWrite),
    .in_msAddress(in_msAddress), .in_msData(in_msData), .in_msID(in_msID),
    .in_smValid(in_smValid), .in_smReady(in_smReady), .in_smData(in_smData),
    .out_msValid(out_msValid), .out_msWrite(out_msWrite), .out_msAddress(out_msAddress),
    .out_msData(out_msData), .out_msID(out_msID), .out_msReady(out_msReady),
    .out_smValid(out_smValid), .out_smData(out_smData), .out_smID(out_smID),
    .out_smReady(out_smReady)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;
  int rr_exp [6] = '{0, 1, 2, 3, 0, 1};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_master(input logic [1:0] i, input logic [31:0] a, input logic [23:0] d, input logic [3:0] id);
    in_msValid[i]   = 1'b1;
    in_msWrite[i]   = 1'b0;
    in_msAddress[i] = a;
    in_msData[i]    = d;
    in_msID[i]      = id;
  endtask

  initial begin
    reset        = 1'b1;
    in_msValid   = '0;
    in_msWrite   = '0;
    in_msAddress = '0;
    in_msData    = '0;
    in_msID      = '0;
    in_smReady   = '0;
    out_msReady  = 1'b0;
    out_smValid  = 1'b0;
    out_smData   = '0;
    out_smID     = '0;
    tick();
    in_msValid = 4'hF;
    #1;
    check("reset_no_accept", 64'(in_msReady), 64'(4'h0));
    tick();
    in_msValid = '0;
    reset      = 1'b0;
    #1;
    check("reset_out_vld",  64'(out_msValid),   64'(1'b0));
    check("reset_rdy",      64'(in_msReady),    64'(4'h0));
    check("reset_sm_vld",   64'(in_smValid),    64'(4'h0));
    check("reset_out_addr", 64'(out_msAddress), 64'(32'h0));

    // Round robin with all masters valid
    out_msReady = 1'b1;
    for (int i = 0; i < 4; i++) set_master(2'(i), 32'h1000 + 32'(i), 24'h10 + 24'(i), 4'(i));
    for (int k = 0; k < 6; k++) begin
      #1;
      check("rr_grant", 64'(in_msReady), 64'(1) << rr_exp[k]);
      if (k > 0) check("rr_out_id", 64'(out_msID), 64'(rr_exp[k-1]));
      tick();
    end
    in_msValid = '0;
    #1;
    check("rr_last_vld",  64'(out_msValid), 64'(1'b1));
    check("rr_last_id",   64'(out_msID),    64'(4'd1));
    check("rr_last_data", 64'(out_msData),  64'(24'h11));
    tick();
    #1;
    check("rr_drained", 64'(out_msValid), 64'(1'b0));

    // Single read from master 2 and its response
    set_master(2'd2, 32'h100, 24'h0, 4'd2);
    #1;
    check("sr_grant", 64'(in_msReady), 64'(4'b0100));
    tick();
    in_msValid = '0;
    #1;
    check("sr_out_vld",  64'(out_msValid),   64'(1'b1));
    check("sr_out_addr", 64'(out_msAddress), 64'(32'h100));
    check("sr_out_id",   64'(out_msID),      64'(4'd2));
    check("sr_out_wr",   64'(out_msWrite),   64'(1'b0));
    tick();
    #1;
    check("sr_drained", 64'(out_msValid), 64'(1'b0));
    in_smReady  = 4'hF;
    out_smValid = 1'b1;
    out_smID    = 4'd2;
    out_smData  = 24'hABCDEF;
    #1;
`ifdef MEMORY_ARBITER_RESP_REG_EN
    check("sr_resp_early", 64'(in_smValid),  64'(4'h0));
    check("sr_resp_rdy",   64'(out_smReady), 64'(1'b1));
    tick();
    out_smValid = 1'b0;
    #1;
    check("sr_resp_vld",  64'(in_smValid), 64'(4'b0100));
    check("sr_resp_data", 64'(in_smData),  64'(24'hABCDEF));
    tick();
    #1;
    check("sr_resp_done", 64'(in_smValid), 64'(4'h0));
`else
    check("sr_resp_vld",  64'(in_smValid),  64'(4'b0100));
    check("sr_resp_data", 64'(in_smData),   64'(24'hABCDEF));
    check("sr_resp_rdy",  64'(out_smReady), 64'(1'b1));
    tick();
    out_smValid = 1'b0;
    #1;
    check("sr_resp_done", 64'(in_smValid), 64'(4'h0));
`endif

    // Back-pressure: ptr is 3, so master 0 wins first
    out_msReady = 1'b0;
    set_master(2'd0, 32'h200, 24'h0, 4'd0);
    set_master(2'd1, 32'h201, 24'h0, 4'd1);
    #1;
    check("bp_grant0", 64'(in_msReady), 64'(4'b0001));
    tick();
    in_msValid[0] = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      check("bp_hold_rdy",  64'(in_msReady),    64'(4'h0));
      check("bp_hold_vld",  64'(out_msValid),   64'(1'b1));
      check("bp_hold_addr", 64'(out_msAddress), 64'(32'h200));
      tick();
    end
    out_msReady = 1'b1;
    #1;
    check("bp_rel_grant", 64'(in_msReady),    64'(4'b0010));
    check("bp_rel_addr0", 64'(out_msAddress), 64'(32'h200));
    tick();
    in_msValid = '0;
    #1;
    check("bp_rel_vld1",  64'(out_msValid),   64'(1'b1));
    check("bp_rel_addr1", 64'(out_msAddress), 64'(32'h201));
    tick();
    #1;
    check("bp_drained", 64'(out_msValid), 64'(1'b0));

    // Response stall toward master 1
    in_smReady  = 4'b1101;
    out_smValid = 1'b1;
    out_smID    = 4'd1;
    out_smData  = 24'h123456;
    #1;
`ifdef MEMORY_ARBITER_RESP_REG_EN
    check("st_load_rdy", 64'(out_smReady), 64'(1'b1));
    check("st_early",    64'(in_smValid),  64'(4'h0));
    tick();
    out_smValid = 1'b0;
    #1;
    check("st_held_vld",  64'(in_smValid), 64'(4'b0010));
    check("st_held_data", 64'(in_smData),  64'(24'h123456));
    tick();
    out_smValid = 1'b1;
    out_smID    = 4'd0;
    out_smData  = 24'h000777;
    #1;
    check("st_still_vld", 64'(in_smValid),  64'(4'b0010));
    check("st_blocked",   64'(out_smReady), 64'(1'b0));
    in_smReady = 4'hF;
    #1;
    check("st_release", 64'(out_smReady), 64'(1'b1));
    tick();
    out_smValid = 1'b0;
    #1;
    check("st_next_vld",  64'(in_smValid), 64'(4'b0001));
    check("st_next_data", 64'(in_smData),  64'(24'h000777));
    tick();
    #1;
    check("st_empty", 64'(in_smValid), 64'(4'h0));
`else
    check("st_blocked", 64'(out_smReady), 64'(1'b0));
    check("st_vld",     64'(in_smValid),  64'(4'b0010));
    tick();
    #1;
    check("st_blocked2", 64'(out_smReady), 64'(1'b0));
    in_smReady = 4'hF;
    #1;
    check("st_release", 64'(out_smReady), 64'(1'b1));
    tick();
    out_smValid = 1'b0;
`endif

    // Unmapped response ID
    in_smReady  = 4'h0;
    out_smValid = 1'b1;
    out_smID    = 4'd7;
    out_smData  = 24'h000999;
    #1;
    check("um_rdy", 64'(out_smReady), 64'(1'b1));
    check("um_vld", 64'(in_smValid),  64'(4'h0));
    tick();
    out_smValid = 1'b0;
    #1;
    check("um_dropped", 64'(in_smValid), 64'(4'h0));

    // Reset while a request is held; ptr is 2 so master 1 wins here
    out_msReady = 1'b0;
    set_master(2'd1, 32'h300, 24'h0, 4'd1);
    #1;
    check("rs_grant", 64'(in_msReady), 64'(4'b0010));
    tick();
    in_msValid = '0;
    #1;
    check("rs_full", 64'(out_msValid), 64'(1'b1));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("rs_cleared", 64'(out_msValid), 64'(1'b0));
    out_msReady = 1'b1;
    for (int i = 0; i < 4; i++) set_master(2'(i), 32'h400 + 32'(i), 24'h0, 4'(i));
    #1;
    check("rs_first_grant", 64'(in_msReady), 64'(4'b0001));
    tick();
    in_msValid = '0;
    #1;
    check("rs_first_addr", 64'(out_msAddress), 64'(32'h400));
    tick();
    tick();
    #1;
    check("rs_no_replay", 64'(out_msValid), 64'(1'b0));

    // Back-to-back responses to master 3
    in_smReady  = 4'hF;
    out_smValid = 1'b1;
    out_smID    = 4'd3;
    for (int k = 0; k < 3; k++) begin
      out_smData = 24'hB0 + 24'(k);
      #1;
      check("b2b_rdy", 64'(out_smReady), 64'(1'b1));
`ifdef MEMORY_ARBITER_RESP_REG_EN
      if (k == 0) begin
        check("b2b_latency", 64'(in_smValid), 64'(4'h0));
      end else begin
        check("b2b_vld",  64'(in_smValid), 64'(4'b1000));
        check("b2b_data", 64'(in_smData),  64'(24'hB0 + 24'(k - 1)));
      end
`else
      check("b2b_vld",  64'(in_smValid), 64'(4'b1000));
      check("b2b_data", 64'(in_smData),  64'(24'hB0 + 24'(k)));
`endif
      tick();
    end
    out_smValid = 1'b0;
    #1;
`ifdef MEMORY_ARBITER_RESP_REG_EN
    check("b2b_tail_vld",  64'(in_smValid), 64'(4'b1000));
    check("b2b_tail_data", 64'(in_smData),  64'(24'hB2));
    tick();
    #1;
`endif
    check("b2b_idle", 64'(in_smValid), 64'(4'h0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Round-robin arbiter merging `NUM_MASTERS` memory-bus masters (ray memory front-ends, frame writer) onto the single memory-bus slave port of the memory controller. It sits directly downstream of each ray memory unit. Requests pass through a one-entry registered request stage. Responses are routed back to the issuing master by `smID`.

## Interface
- `NUM_MASTERS`, 4: number of upstream master ports. Port `i` belongs to master `MASTER_ID == i`.
- `DATA_WIDTH`, 24: bus data width.
- `ADDRESS_WIDTH`, 32: bus address width.
- `ID_WIDTH`, 4: width of `msID`/`smID`. Must satisfy `2**ID_WIDTH >= NUM_MASTERS`.

Ports:
- `clock`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `in_msValid`  in  [NUM_MASTERS]  request valid, per master.
- `in_msReady`  out  [NUM_MASTERS]  request accepted, per master.
- `in_msWrite`  in  [NUM_MASTERS]  write flag, per master.
- `in_msAddress`  in  [NUM_MASTERS] x ADDRESS_WIDTH  request address.
- `in_msData`  in  [NUM_MASTERS] x DATA_WIDTH  write data.
- `in_msID`  in  [NUM_MASTERS] x ID_WIDTH  master ID; passed through unchanged.
- `in_smValid`  out  [NUM_MASTERS]  response valid, per master.
- `in_smReady`  in  [NUM_MASTERS]  master can take a response.
- `in_smData`  out  DATA_WIDTH  response data, broadcast to all masters.
- `out_msValid`, `out_msWrite`, `out_msAddress`, `out_msData`, `out_msID`  out  request to the slave.
- `out_msReady`  in  1  slave accepts the request.
- `out_smValid`, `out_smData`, `out_smID`  in  response from the slave.
- `out_smReady`  out  1  arbiter accepts the response.

## Operation
- **Request register.** A single entry holds {write, address, data, id}. `out_ms*` is driven from the register. `out_msValid` = register full.
- **Load condition.** `load_ok = !full || out_msReady`.
- **Arbitration.**
  - The grant `g` is the first index `i` with `in_msValid[i]`, searching upward from `ptr` with wrap-around from `NUM_MASTERS-1` to 0.
  - When `load_ok` and some master is valid: `in_msReady[g]=1` (combinational, one-hot), the register loads from port `g`, and `ptr <= (g+1) mod NUM_MASTERS`.
  - Every other `in_msReady` bit is 0.
- **Register update.**
  - If the register drains (`out_msValid && out_msReady`) with no load, `full <= 0`.
  - A drain and a load in the same cycle keep `full=1` with the new contents. No bubble occurs.
- **Response routing.**
  - `in_smValid[i] = out_smValid && (out_smID == i)`.
  - `in_smData = out_smData`.
  - `out_smReady = in_smReady[out_smID]`.
- **Unmapped IDs.** If `out_smID >= NUM_MASTERS`, `out_smReady = 1`, the response is discarded, and no `in_smValid` is raised.
- The arbiter does not track outstanding reads. Masters issue one read at a time and wait for the response.

## Timing
- **Reset values:** `full=0`, `out_msValid=0`, `ptr=0`, `in_msReady=0`, `in_smValid=0`. Register data resets to 0.
- **Request latency:** a request accepted at edge t appears on `out_ms*` in cycle t+1.
- **Throughput:** one request per cycle when `out_msReady` is held high.
- **Fairness:** a continuously valid master waits at most `NUM_MASTERS-1` grants.
- **Response latency:** 0 cycles, combinational pass-through, unless `MEMORY_ARBITER_RESP_REG_EN` is defined.
- **Back-pressure:** `out_msValid` and the register contents hold stable while `out_msReady=0`.
- **Reset mid-transaction:** reset clears a full register without issuing it. The dropped request is never replayed.

## Configuration
- `MEMORY_ARBITER_RESP_REG_EN` defined:
  - A one-entry response register (`rfull`, data, id) is inserted using the same drain/load rule.
  - `out_smReady = !rfull || (routed in_smReady of the held entry)`.
  - `in_smValid` is driven from the register, giving 1 cycle of latency.
  - `rfull` resets to 0.
  - Unmapped IDs are dropped at load and never enter the register.
- Undefined: responses are combinational as described in Operation.

## Test plan
- Single request:
  - Stimulus: master 2 reads address 0x100 with ID 2, and `out_msReady=1`.
  - Response: `in_msReady[2]` is high at cycle 0, and `out_msValid` is high with address 0x100 and ID 2 at cycle 1.
  - Then `out_smValid` with ID 2 and data 0xABCDEF raises only `in_smValid[2]` with data 0xABCDEF.
- Round robin:
  - Stimulus: all four masters continuously valid, `out_msReady=1`.
  - Response: grant order 0,1,2,3,0,1.
- Back-pressure:
  - Stimulus: `out_msReady=0` for 5 cycles while masters 0 and 1 are valid.
  - Response: one request is registered and held stable, with no further `in_msReady`.
  - On release: requests 0 and 1 issue on consecutive cycles.
- Response stall:
  - Stimulus: response with ID 1 while `in_smReady[1]=0`.
  - Response: `out_smReady=0` until master 1 is ready.
  - Unmapped ID 7 (`NUM_MASTERS=4`): `out_smReady=1` and no `in_smValid`.
- Reset:
  - Stimulus: reset asserted while the register is full and `out_msReady=0`.
  - Response: `out_msValid=0` the next cycle, and `ptr` returns to 0, so the first grant after reset goes to master 0.
- With `MEMORY_ARBITER_RESP_REG_EN`:
  - Stimulus: a response to master 3.
  - Response: `in_smValid[3]` rises one cycle after `out_smValid`.
  - Back-to-back responses sustain one per cycle.
